// File: rtl/npu_host_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_host_bridge: loads matrices A/B into the NPU, issues descriptors and |
// | commits the NPU writeback stream to data memory.                         |
// | Optional: NPU_HOST_BRIDGE_TIMEOUT_EN adds o_err and a RUN-cycle watchdog. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module npu_host_bridge #(
  parameter int DATA_W = 32,
  parameter int MAT_N  = 9,
  parameter int B_SLOT = 9
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_base_a,
  input  logic [DATA_W-1:0] i_base_b,
  input  logic [DATA_W-1:0] i_base_c,
  output logic              o_busy,
  output logic              o_done,
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  output logic              o_err,
`endif
  output logic [3:0]        o_wb_count,
  output logic              o_dmem_re,
  output logic [DATA_W-1:0] o_dmem_raddr,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_waddr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic              o_npu_en,
  output logic              o_npu_get_wr,
  output logic [DATA_W-1:0] o_npu_get_data,
  output logic [DATA_W-1:0] o_npu_get_addr,
  output logic [DATA_W-1:0] o_npu_mem_addr,
  input  logic              i_npu_pass_we,
  input  logic [DATA_W-1:0] i_npu_modified_addr,
  input  logic [DATA_W-1:0] i_npu_modified_data,
  input  logic              i_npu_ack
);

  localparam int                IDX_W       = $clog2(2*MAT_N+1);
  localparam logic [IDX_W-1:0]  c_last      = IDX_W'(2*MAT_N);
  localparam logic [IDX_W-1:0]  c_mat_n     = IDX_W'(MAT_N);
  localparam logic [3:0]        c_wb_max    = 4'(MAT_N);
  localparam logic [DATA_W-1:0] c_word_mask = {{(DATA_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DESC = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_slot;
  logic [DATA_W-1:0] r_base_a;
  logic [DATA_W-1:0] r_base_b;
  logic [DATA_W-1:0] r_base_c;
  logic              r_wb_we;
  logic [DATA_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic [3:0]        r_wb_count;
  logic              w_accept;
  logic              w_wb_take;
  logic              w_wb_done;
  logic              w_finish;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_wb_take = i_npu_pass_we && ((r_state == S_DESC) || (r_state == S_RUN));
  // Completion counts samples, so a MAT_N-th write seen during DESC still ends RUN at once.
  assign w_wb_done = (r_wb_count >= c_wb_max) ||
                     (i_npu_pass_we && (r_wb_count == (c_wb_max - 4'd1)));
  assign w_finish  = w_wb_done || i_npu_ack;

`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  localparam int               RUN_W      = $clog2(TIMEOUT+1);
  localparam logic [RUN_W-1:0] c_run_last = RUN_W'(TIMEOUT-1);

  logic [RUN_W-1:0] r_run_cnt;
  logic             r_err;
  logic             w_timeout;

  assign w_timeout = (r_state == S_RUN) && (r_run_cnt == c_run_last) && !w_finish;
  assign o_err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_base_c   <= '0;
      r_wb_we    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_count <= '0;
    end else begin
      if (r_state != w_next) begin
        r_idx <= '0;
      end else if ((r_state == S_LOAD) || (r_state == S_DESC)) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_accept) begin
        r_base_a   <= i_base_a & c_word_mask;
        r_base_b   <= i_base_b & c_word_mask;
        r_base_c   <= i_base_c & c_word_mask;
        r_wb_count <= '0;
      end
      r_wb_we <= w_wb_take;
      if (w_wb_take) begin
        r_wb_addr <= i_npu_modified_addr & c_word_mask;
        r_wb_data <= i_npu_modified_data;
        if (r_wb_count != c_wb_max) begin
          r_wb_count <= r_wb_count + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_slot         = r_idx - 1'b1;
    o_busy         = (r_state != S_IDLE);
    o_done         = 1'b0;
    o_dmem_re      = 1'b0;
    o_dmem_raddr   = '0;
    o_npu_en       = 1'b0;
    o_npu_get_wr   = 1'b0;
    o_npu_get_data = '0;
    o_npu_get_addr = '0;
    o_npu_mem_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        // Read n is issued in cycle n; its data is pushed to slot n in cycle n+1.
        if (r_idx != c_last) begin
          o_dmem_re    = 1'b1;
          o_dmem_raddr = (r_idx < c_mat_n) ? r_base_a + (DATA_W'(r_idx) << 2)
                                           : r_base_b + (DATA_W'(r_idx - c_mat_n) << 2);
        end else begin
          w_next = S_DESC;
        end
        if (r_idx != '0) begin
          o_npu_get_wr   = 1'b1;
          o_npu_get_data = i_dmem_rdata;
          o_npu_mem_addr = DATA_W'(w_slot);
          o_npu_get_addr = DATA_W'(w_slot) << 2;
        end
      end
      S_DESC: begin
        o_npu_en = 1'b1;
        if (r_idx == IDX_W'(0)) begin
          o_npu_get_data = '0;
        end else if (r_idx == IDX_W'(1)) begin
          o_npu_get_data = DATA_W'(4*B_SLOT);
        end else begin
          o_npu_get_data = r_base_c;
          w_next         = S_RUN;
        end
      end
      S_RUN: begin
        o_npu_en = 1'b1;
        if (w_finish) w_next = S_DONE;
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
        if (w_timeout) w_next = S_DONE;
`endif
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_dmem_we    = r_wb_we;
  assign o_dmem_waddr = r_wb_addr;
  assign o_dmem_wdata = r_wb_data;
  assign o_wb_count   = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_npu_host_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_npu_host_bridge: directed self-checking bench for npu_host_bridge.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_npu_host_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_base_a = '0, i_base_b = '0, i_base_c = '0;
  logic        o_busy, o_done, o_dmem_re, o_dmem_we, o_npu_en, o_npu_get_wr;
  logic [3:0]  o_wb_count;
  logic [31:0] o_dmem_raddr, o_dmem_waddr, o_dmem_wdata;
  logic [31:0] o_npu_get_data, o_npu_get_addr, o_npu_mem_addr;
  logic [31:0] i_dmem_rdata;
  logic        i_npu_pass_we = 1'b0, i_npu_ack = 1'b0;
  logic [31:0] i_npu_modified_addr = '0, i_npu_modified_data = '0;
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  logic        o_err;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  int          wr_cnt = 0;
  int          done_seen = 0;
  logic [31:0] mem  [0:255];
  logic [31:0] wmem [0:255];
  logic [201:0] all_outs;

  assign all_outs = {o_busy, o_done, o_dmem_re, o_dmem_we, o_npu_en, o_npu_get_wr, o_wb_count,
                     o_dmem_raddr, o_dmem_waddr, o_dmem_wdata,
                     o_npu_get_data, o_npu_get_addr, o_npu_mem_addr};

`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  npu_host_bridge #(.DATA_W(32), .MAT_N(9), .B_SLOT(9), .TIMEOUT(20)) dut (
`else
  npu_host_bridge #(.DATA_W(32), .MAT_N(9), .B_SLOT(9)) dut (
`endif
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_base_a(i_base_a), .i_base_b(i_base_b), .i_base_c(i_base_c),
    .o_busy(o_busy), .o_done(o_done),
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
    .o_err(o_err),
`endif
    .o_wb_count(o_wb_count),
    .o_dmem_re(o_dmem_re), .o_dmem_raddr(o_dmem_raddr), .i_dmem_rdata(i_dmem_rdata),
    .o_dmem_we(o_dmem_we), .o_dmem_waddr(o_dmem_waddr), .o_dmem_wdata(o_dmem_wdata),
    .o_npu_en(o_npu_en), .o_npu_get_wr(o_npu_get_wr), .o_npu_get_data(o_npu_get_data),
    .o_npu_get_addr(o_npu_get_addr), .o_npu_mem_addr(o_npu_mem_addr),
    .i_npu_pass_we(i_npu_pass_we), .i_npu_modified_addr(i_npu_modified_addr),
    .i_npu_modified_data(i_npu_modified_data), .i_npu_ack(i_npu_ack)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, writes logged to a separate image.
  always @(posedge clk) begin
    if (o_dmem_re) i_dmem_rdata <= mem[o_dmem_raddr[9:2]];
    if (o_dmem_we) begin
      wmem[o_dmem_waddr[9:2]] <= o_dmem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (o_done) done_seen <= done_seen + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one step after a rising edge while idle; returns in LOAD cycle 0.
  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    i_start  = 1'b1;
    i_base_a = a;
    i_base_b = b;
    i_base_c = c;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 256; k++) begin
      mem[k]  = '0;
      wmem[k] = '0;
    end
    rst = 1'b1;
    tick(2);
    n_total++;
    if (all_outs !== '0) $display("FAIL reset_outputs got %h exp 0", all_outs);
    else n_pass++;
    rst = 1'b0;
    tick(1);
    n_total++;
    if ({o_busy, o_done, o_wb_count} !== 6'd0)
      $display("FAIL reset_idle got %b exp 0", {o_busy, o_done, o_wb_count});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [131:0] obs, exp;
    logic [31:0]  ea, ev;
    int           s;
    for (int k = 0; k < 9; k++) begin
      mem[64 + k]  = 32'(k + 1);
      mem[128 + k] = (k % 4 == 0) ? 32'd1 : 32'd0;
    end
    start_job(32'h100, 32'h200, 32'h300);
    for (int n = 0; n < 19; n++) begin
      ea = (n < 9) ? 32'h100 + 32'(4*n) : 32'h200 + 32'(4*(n-9));
      s  = n - 1;
      ev = (s < 9) ? 32'(s + 1) : (((s - 9) % 4 == 0) ? 32'd1 : 32'd0);
      exp = {(n < 18), (n < 18) ? ea : 32'h0, (n > 0),
             (n > 0) ? 32'(s) : 32'h0, (n > 0) ? 32'(4*s) : 32'h0, (n > 0) ? ev : 32'h0,
             1'b1, 1'b0};
      obs = {o_dmem_re, (n < 18) ? o_dmem_raddr : 32'h0, o_npu_get_wr,
             (n > 0) ? o_npu_mem_addr : 32'h0, (n > 0) ? o_npu_get_addr : 32'h0,
             (n > 0) ? o_npu_get_data : 32'h0, o_busy, o_npu_en};
      n_total++;
      if (obs !== exp) $display("FAIL basic_load n=%0d got %h exp %h", n, obs, exp);
      else n_pass++;
      tick(1);
    end
    for (int d = 0; d < 3; d++) begin
      ev = (d == 0) ? 32'd0 : ((d == 1) ? 32'd36 : 32'h300);
      n_total++;
      if ({o_npu_en, o_npu_get_wr, o_npu_get_data} !== {2'b10, ev})
        $display("FAIL basic_desc d=%0d got %h exp %h", d,
                 {o_npu_en, o_npu_get_wr, o_npu_get_data}, {2'b10, ev});
      else n_pass++;
      tick(1);
    end
    n_total++;
    if ({o_npu_en, o_npu_get_data, o_dmem_we, o_wb_count} !== {1'b1, 32'd0, 1'b0, 4'd0})
      $display("FAIL basic_run_entry got %h", {o_npu_en, o_npu_get_data, o_dmem_we, o_wb_count});
    else n_pass++;
    for (int k = 0; k < 9; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'(k + 1);
      tick(1);
      exp = {62'd0, o_busy, (k == 8), (k != 8), 1'b1, 32'h300 + 32'(4*k), 32'(k + 1), 4'(k + 1)};
      obs = {62'd0, 1'b1, o_done, o_npu_en, o_dmem_we, o_dmem_waddr, o_dmem_wdata, o_wb_count};
      n_total++;
      if (obs !== exp || o_busy !== 1'b1)
        $display("FAIL basic_wb k=%0d got %h exp %h busy %b", k, obs, exp, o_busy);
      else n_pass++;
    end
    i_npu_pass_we = 1'b0;
    tick(1);
    n_total++;
    if ({o_busy, o_done, o_dmem_we, o_npu_en, o_wb_count} !== {4'b0000, 4'd9})
      $display("FAIL basic_idle got %b exp 00009", {o_busy, o_done, o_dmem_we, o_npu_en, o_wb_count});
    else n_pass++;
    for (int k = 0; k < 9; k++) begin
      n_total++;
      if (wmem[192 + k] !== 32'(k + 1))
        $display("FAIL basic_mem k=%0d got %h exp %h", k, wmem[192 + k], 32'(k + 1));
      else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    start_job(32'h103, 32'h202, 32'h301);
    n_total++;
    if (o_dmem_raddr !== 32'h100) $display("FAIL mis_raddr_a got %h exp 00000100", o_dmem_raddr);
    else n_pass++;
    tick(9);
    n_total++;
    if (o_dmem_raddr !== 32'h200) $display("FAIL mis_raddr_b got %h exp 00000200", o_dmem_raddr);
    else n_pass++;
    tick(12);
    n_total++;
    if (o_npu_get_data !== 32'h300) $display("FAIL mis_desc_c got %h exp 00000300", o_npu_get_data);
    else n_pass++;
    tick(1);
    i_npu_pass_we       = 1'b1;
    i_npu_modified_addr = 32'h307;
    i_npu_modified_data = 32'hABCD;
    tick(1);
    i_npu_pass_we = 1'b0;
    n_total++;
    if ({o_dmem_we, o_dmem_waddr, o_dmem_wdata} !== {1'b1, 32'h304, 32'hABCD})
      $display("FAIL mis_waddr got %h exp %h", {o_dmem_we, o_dmem_waddr, o_dmem_wdata},
               {1'b1, 32'h304, 32'hABCD});
    else n_pass++;
    i_npu_ack = 1'b1;
    tick(1);
    i_npu_ack = 1'b0;
    n_total++;
    if ({o_done, o_wb_count} !== {1'b1, 4'd1})
      $display("FAIL mis_done got %h exp 11", {o_done, o_wb_count});
    else n_pass++;
    tick(1);
  endtask

  task automatic test_start_while_busy();
    int          d0;
    logic [31:0] ea;
    d0 = done_seen;
    start_job(32'h100, 32'h200, 32'h300);
    for (int n = 0; n < 18; n++) begin
      if (n == 5) begin
        i_start  = 1'b1;
        i_base_a = 32'h0;
        i_base_b = 32'h40;
      end else begin
        i_start = 1'b0;
      end
      ea = (n < 9) ? 32'h100 + 32'(4*n) : 32'h200 + 32'(4*(n-9));
      n_total++;
      if ({o_dmem_re, o_dmem_raddr} !== {1'b1, ea})
        $display("FAIL busy_start_raddr n=%0d got %h exp %h", n, {o_dmem_re, o_dmem_raddr}, {1'b1, ea});
      else n_pass++;
      tick(1);
    end
    tick(4);
    for (int k = 0; k < 9; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'(k + 1);
      tick(1);
    end
    i_npu_pass_we = 1'b0;
    tick(3);
    n_total++;
    if (done_seen - d0 != 1 || o_wb_count !== 4'd9)
      $display("FAIL busy_start_done got dones=%0d wb=%0d exp dones=1 wb=9", done_seen - d0, o_wb_count);
    else n_pass++;
  endtask

  task automatic test_early_ack();
    start_job(32'h100, 32'h200, 32'h300);
    tick(22);
    for (int k = 0; k < 4; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'h50 + 32'(k);
      tick(1);
    end
    i_npu_pass_we = 1'b0;
    i_npu_ack     = 1'b1;
    tick(1);
    i_npu_ack = 1'b0;
    n_total++;
    if ({o_done, o_busy, o_npu_en, o_dmem_we, o_wb_count} !== {4'b1100, 4'd4})
      $display("FAIL early_ack_done got %b exp 11000100", {o_done, o_busy, o_npu_en, o_dmem_we, o_wb_count});
    else n_pass++;
    tick(1);
    n_total++;
    if ({o_busy, o_done, o_wb_count} !== {2'b00, 4'd4})
      $display("FAIL early_ack_idle got %b exp 000100", {o_busy, o_done, o_wb_count});
    else n_pass++;
  endtask

  task automatic test_ack_with_last();
    int d0;
    d0 = done_seen;
    start_job(32'h100, 32'h200, 32'h300);
    tick(22);
    for (int k = 0; k < 9; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_ack           = (k == 8);
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'h90 + 32'(k);
      tick(1);
    end
    i_npu_pass_we = 1'b0;
    i_npu_ack     = 1'b0;
    n_total++;
    if ({o_done, o_dmem_we, o_dmem_wdata, o_wb_count} !== {2'b11, 32'h98, 4'd9})
      $display("FAIL ack_last_done got %h exp %h", {o_done, o_dmem_we, o_dmem_wdata, o_wb_count},
               {2'b11, 32'h98, 4'd9});
    else n_pass++;
    tick(2);
    n_total++;
    if (o_busy !== 1'b0 || done_seen - d0 != 1)
      $display("FAIL ack_last_single got busy=%b dones=%0d exp busy=0 dones=1", o_busy, done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int w0;
    start_job(32'h100, 32'h200, 32'h300);
    tick(22);
    for (int k = 0; k < 3; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'h60 + 32'(k);
      tick(1);
    end
    i_npu_pass_we = 1'b0;
    tick(1);
    w0 = wr_cnt;
    i_npu_pass_we       = 1'b1;
    i_npu_modified_addr = 32'h30C;
    i_npu_modified_data = 32'h63;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (all_outs !== '0) $display("FAIL rst_mid_outputs got %h exp 0", all_outs);
    else n_pass++;
    tick(2);
    i_npu_pass_we = 1'b0;
    rst = 1'b0;
    tick(1);
    n_total++;
    if (wr_cnt != w0 || o_busy !== 1'b0)
      $display("FAIL rst_mid_nowrite got writes=%0d busy=%b exp writes=%0d busy=0", wr_cnt, o_busy, w0);
    else n_pass++;
    start_job(32'h100, 32'h200, 32'h300);
    tick(22);
    for (int k = 0; k < 9; k++) begin
      i_npu_pass_we       = 1'b1;
      i_npu_modified_addr = 32'h300 + 32'(4*k);
      i_npu_modified_data = 32'h70 + 32'(k);
      tick(1);
    end
    i_npu_pass_we = 1'b0;
    n_total++;
    if ({o_done, o_wb_count} !== {1'b1, 4'd9})
      $display("FAIL rst_mid_rerun got %h exp 19", {o_done, o_wb_count});
    else n_pass++;
    tick(1);
    n_total++;
    if (wr_cnt - w0 != 9 || wmem[200] !== 32'h78)
      $display("FAIL rst_mid_rerun_mem got writes=%0d last=%h exp writes=9 last=00000078",
               wr_cnt - w0, wmem[200]);
    else n_pass++;
  endtask

`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    start_job(32'h100, 32'h200, 32'h300);
    tick(22);
    cnt = 0;
    while (o_done !== 1'b1 && cnt < 100) begin
      tick(1);
      cnt++;
    end
    n_total++;
    if (cnt != 20 || o_err !== 1'b1)
      $display("FAIL timeout_fire got cycles=%0d err=%b exp cycles=20 err=1", cnt, o_err);
    else n_pass++;
    tick(1);
    n_total++;
    if ({o_busy, o_err} !== 2'b01) $display("FAIL timeout_hold got %b exp 01", {o_busy, o_err});
    else n_pass++;
    start_job(32'h100, 32'h200, 32'h300);
    n_total++;
    if (o_err !== 1'b0) $display("FAIL timeout_clear got %b exp 0", o_err);
    else n_pass++;
    tick(22);
    i_npu_ack = 1'b1;
    tick(1);
    i_npu_ack = 1'b0;
    tick(1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_start_while_busy();
    test_early_ack();
    test_ack_with_last();
    test_reset_mid_run();
`ifdef NPU_HOST_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
